reconfig_topology_sequencer: RTL

//  Upstream job sequencer for the reconfigurable multi-topology adder datapath (y = b + {a1|a2|a3|0}).
//  - Accepts one operand job (a1,a2,a3,b) per valid/ready handshake and holds the operands on the datapath.
//  - Steps the topology select s0/s1 through all four configurations, one per cycle.
//  - Registers each 9-bit dp_y result into a backpressured output stream, with a running 11-bit job sum.

---
 rtl/reconfig_topology_pkg.sv | 31 +++
 rtl/reconfig_step_ctr.sv | 69 ++++++
 rtl/reconfig_topology_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/reconfig_topology_pkg.sv
// Shared types and helpers for the reconfigurable-topology job sequencer.
// Holds the FSM state enum, topology step codes and the step->{s0,s1} map.
package reconfig_topology_pkg;

    localparam int DW_DEF    = 8;
    localparam int SUM_W_DEF = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] TOPO_A1   = 2'd0;
    localparam logic [1:0] TOPO_A2   = 2'd1;
    localparam logic [1:0] TOPO_A3   = 2'd2;
    localparam logic [1:0] TOPO_ZERO = 2'd3;

    // Returns {s0, s1} for a step code.
    function automatic logic [1:0] topo_sel(input logic [1:0] step);
        logic [1:0] sel;
        unique case (step)
            TOPO_A1:   sel = 2'b00;
            TOPO_A2:   sel = 2'b01;
            TOPO_A3:   sel = 2'b10;
            TOPO_ZERO: sel = 2'b11;
            default:   sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reconfig_step_ctr.sv
// Step register for the sequencer: latches the job's step-enable mask and
// walks the enabled steps. Ports: load_i/mask_i start a job at the first
// enabled step, adv_i moves to the next one, last_o flags the final step.
module reconfig_step_ctr
    import reconfig_topology_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] mask_i,
    input  logic       adv_i,
    output logic [1:0] step_o,
    output logic       last_o
);

    logic [3:0] mask_q, mask_d;
    logic [1:0] step_q, step_d;
    logic [3:0] mask_eff;
    logic [1:0] first_step;
    logic [1:0] next_step;
    logic       more_above;

    // An empty mask would give a job with no beats; run every step instead.
    assign mask_eff = (mask_i == 4'b0000) ? 4'b1111 : mask_i;

    always_comb begin
        first_step = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_eff[i]) first_step = 2'(i);
        end
    end

    // Lowest enabled step strictly above the current one.
    always_comb begin
        next_step  = step_q;
        more_above = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(step_q))) begin
                next_step  = 2'(i);
                more_above = 1'b1;
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
        step_d = step_q;
        if (load_i) begin
            mask_d = mask_eff;
            step_d = first_step;
        end else if (adv_i) begin
            step_d = next_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 4'b1111;
            step_q <= 2'd0;
        end else begin
            mask_q <= mask_d;
            step_q <= step_d;
        end
    end

    assign step_o = step_q;
    assign last_o = !more_above;

endmodule

// File: rtl/reconfig_topology_sequencer.sv
// Job sequencer for the multi-topology adder y = b + {a1|a2|a3|0}: accepts
// one job per in_valid/in_ready handshake, holds operands on dp_*, steps
// dp_s0/dp_s1 through the topologies and streams each dp_y out with a
// running sum (out_valid/out_ready, out_data/out_idx/out_last/out_sum).
// Optional RECONFIG_SEQ_CFG_MASK_EN adds cfg_mask to skip steps per job.
module reconfig_topology_sequencer
    import reconfig_topology_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a1,
    input  logic [DW-1:0]    in_a2,
    input  logic [DW-1:0]    in_a3,
    input  logic [DW-1:0]    in_b,
`ifdef RECONFIG_SEQ_CFG_MASK_EN
    input  logic [3:0]       cfg_mask,
`endif
    output logic [DW-1:0]    dp_a1,
    output logic [DW-1:0]    dp_a2,
    output logic [DW-1:0]    dp_a3,
    output logic [DW-1:0]    dp_b,
    output logic             dp_s0,
    output logic             dp_s1,
    input  logic [DW:0]      dp_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW:0]      out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic [SUM_W-1:0] out_sum
);

    state_t           state_q, state_d;
    logic [DW-1:0]    a1_q, a2_q, a3_q, b_q;
    logic [SUM_W-1:0] sum_q;
    logic             ovalid_q;
    logic [DW:0]      odata_q;
    logic [1:0]       oidx_q;
    logic             olast_q;
    logic [SUM_W-1:0] osum_q;

    logic             accept;
    logic             capture;
    logic [1:0]       step;
    logic             step_last;
    logic [3:0]       job_mask;
    logic [1:0]       sel;
    logic [SUM_W-1:0] sum_next;

`ifdef RECONFIG_SEQ_CFG_MASK_EN
    assign job_mask = cfg_mask;
`else
    assign job_mask = 4'b1111;
`endif

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    // A stalled beat blocks the next capture, even for a freshly accepted job.
    assign capture  = (state_q == RUN) && (!ovalid_q || out_ready);
    assign sum_next = sum_q + SUM_W'(dp_y);

    reconfig_step_ctr u_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .mask_i (job_mask),
        .adv_i  (capture),
        .step_o (step),
        .last_o (step_last)
    );

    always_comb begin
        state_d = state_q;
        sel     = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                sel = topo_sel(step);
                if (capture && step_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a1_q  <= in_a1;
                a2_q  <= in_a2;
                a3_q  <= in_a3;
                b_q   <= in_b;
                sum_q <= '0;
            end else if (capture) begin
                sum_q <= sum_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            oidx_q   <= '0;
            olast_q  <= 1'b0;
            osum_q   <= '0;
        end else if (capture) begin
            ovalid_q <= 1'b1;
            odata_q  <= dp_y;
            oidx_q   <= step;
            olast_q  <= step_last;
            osum_q   <= sum_next;
        end else if (out_ready) begin
            ovalid_q <= 1'b0;
        end
    end

    assign dp_a1     = a1_q;
    assign dp_a2     = a2_q;
    assign dp_a3     = a3_q;
    assign dp_b      = b_q;
    assign dp_s0     = sel[1];
    assign dp_s1     = sel[0];
    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
    assign out_idx   = oidx_q;
    assign out_last  = olast_q;
    assign out_sum   = osum_q;

endmodule
